count_connected_iterative_core: RTL and testbench
=================================================

Name: count_connected_iterative_core

Overview:
- Parametrised successor of the fixed 128-bit pipelined connected-component counter.
- Counts connected components of a graph given as a 2^VARIABLES-bit set over the boolean lattice. Two set bits are adjacent when comparable under up/down monotonization restricted to the leftover graph.
- Single-graph FSM with valid/ready handshakes on input and output, one exploration step per cycle, extra data carried through.
- Sits between the graph feeder and the count collector; multiple instances are tiled per compute lane.

Parameters:
VARIABLES, 7, lattice dimension; graph width GW = 2^VARIABLES bits.
COUNT_WIDTH, 6, width of component count.
EXTRA_DATA_WIDTH, 10, width of opaque side data carried with each graph.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  graph offered.
in_ready  output  1  core idle, accepts graph.
graph_in  input  GW  graph bitset.
start_count_in  input  COUNT_WIDTH  initial count, added to the result.
extra_in  input  EXTRA_DATA_WIDTH  side data.
out_valid  output  1  result held.
out_ready  input  1  collector accepts result.
count_out  output  COUNT_WIDTH  component count.
overflow_out  output  1  count saturated.
extra_out  output  EXTRA_DATA_WIDTH  side data of the graph.

Behaviour:
- Reset values: FSM=IDLE; in_ready=1; out_valid=0; count_out, overflow_out, extra_out, internal leftover and cur registers all 0.
- States are IDLE, SEED, EXPLORE, DONE.
- IDLE:
  - Transfer when in_valid&in_ready.
  - On transfer: leftover<=graph_in, count<=start_count_in, extra<=extra_in, overflow<=0, go to SEED.
  - in_ready=1 only in IDLE.
- SEED:
  - If leftover==0, go to DONE.
  - Otherwise cur<=one-hot of the lowest set bit of leftover (priority encoder), count increments, go to EXPLORE.
- EXPLORE, one step per cycle:
  - mid=monoUp(cur)&leftover; nxt=monoDown(mid)&leftover.
  - monoUp: for each variable v in 0..VARIABLES-1, bit i with bit v set ORs in bit i^(1<<v), cascaded over all v.
  - monoDown is the symmetric operation over clear bits.
  - If nxt==cur: leftover<=leftover&~cur, go to SEED. Otherwise cur<=nxt and stay in EXPLORE.
- DONE:
  - out_valid=1; count_out, overflow_out and extra_out are stable.
  - On out_valid&out_ready: out_valid<=0, go to IDLE.
  - in_ready stays 0 until IDLE, so there is no input/output overlap in the same cycle.
- Count arithmetic:
  - Unsigned, COUNT_WIDTH bits.
  - Increment at all-ones holds all-ones and sets overflow; overflow is sticky until the next accept.
- Latency: accept → SEED in 1 cycle. Each component costs 1 SEED cycle plus k EXPLORE cycles, where k ≥ 1 (one extra cycle for the fixpoint check). The final SEED with empty leftover → DONE costs 1 cycle.
- An empty graph reaches out_valid 2 cycles after accept.
- Reset asserted mid-operation aborts immediately to the reset values. The partial result is discarded and out_valid is never raised.
- graph_in, start_count_in and extra_in are sampled only on transfer; changes while in_ready=0 are ignored.

Optional Feature:
COUNT_CONNECTED_SINGLETON_SHORTCUT_EN
- With the macro defined, the IDLE transfer goes to an extra PRUNE state for 1 cycle:
  - Compute iso = leftover & ~(monoUp(ones-of-leftover-except-self) | monoDown(...)), i.e. bits with no comparable neighbour in the graph.
  - count += popcount(iso) with saturation; leftover &= ~iso; then go to SEED.
- This cuts cycles for antichain-heavy graphs.
- Without the macro there is no PRUNE state and singletons go through SEED/EXPLORE normally.
- Final count_out is identical with or without the macro. Only latency differs.

Decomposition:
- Shared package holds:
  - state enum (IDLE, SEED, EXPLORE, DONE, PRUNE);
  - function GW(VARIABLES);
  - mono_up/mono_down functions parametrised by VARIABLES;
  - saturating add helper.
- One sub-module: count_connected_lowest_bit_select, a GW-wide parametrised priority encoder returning the one-hot lowest set bit and an any-bit flag. It is reused by future lanes.

Test Plan:
- Empty graph 0x0, start_count=0 → count_out=0, out_valid exactly 2 cycles after accept, overflow=0.
- VARIABLES=7, graph bits {1,2} (x0, x1 incomparable) → count_out=2. Graph bits {1,3} → count_out=1.
- Graph all-ones (128 bits), start_count=5 → count_out=6.
- COUNT_WIDTH=2, start_count=3, graph bits {1,2} → count_out=3, overflow_out=1.
- Backpressure: hold out_ready=0 for 20 cycles → out_valid, count and extra stable, in_ready=0 throughout. Then out_ready=1 → in_ready=1 the next cycle and a new graph is accepted.
- Assert rst low during EXPLORE of graph {1,3} → all outputs return to reset values asynchronously. After release, a new graph {4} → count_out=1, extra_out matches the new extra_in.

Source files
------------

// File: rtl/count_connected_iterative_core_pkg.sv
// Shared types and lattice helpers for the iterative connected-component counter.
// Helpers work on a maximum-width lattice; callers zero-extend and take the low GW bits.
package count_connected_iterative_core_pkg;

  localparam int MAX_VARIABLES   = 8;
  localparam int MAX_GW          = 1 << MAX_VARIABLES;
  localparam int MAX_COUNT_WIDTH = 16;

  typedef logic [MAX_GW-1:0]          maxGraph_t;
  typedef logic [MAX_COUNT_WIDTH-1:0] maxCount_t;
  typedef logic [MAX_COUNT_WIDTH:0]   satSum_t;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    EXPLORE,
    DONE,
    PRUNE
  } coreState_t;

  function automatic int calcGw(input int variables);
    return 1 << variables;
  endfunction

  // Upward closure: every element reaches all of its supersets within the lattice.
  function automatic maxGraph_t monoUp(input maxGraph_t g, input int variables);
    maxGraph_t r;
    r = g;
    for (int v = 0; v < MAX_VARIABLES; v++) begin
      if (v < variables) begin
        for (int i = 0; i < MAX_GW; i++) begin
          if (i[v]) r[i] = r[i] | r[i ^ (1 << v)];
        end
      end
    end
    return r;
  endfunction

  function automatic maxGraph_t monoDown(input maxGraph_t g, input int variables);
    maxGraph_t r;
    r = g;
    for (int v = 0; v < MAX_VARIABLES; v++) begin
      if (v < variables) begin
        for (int i = 0; i < MAX_GW; i++) begin
          if (!i[v]) r[i] = r[i] | r[i | (1 << v)];
        end
      end
    end
    return r;
  endfunction

  // Returns {overflow, sum}; sum is clamped to the all-ones value of a width-bit count.
  function automatic satSum_t satAdd(input maxCount_t a, input maxCount_t b, input int width);
    satSum_t sum;
    satSum_t limit;
    sum   = {1'b0, a} + {1'b0, b};
    limit = satSum_t'((1 << width) - 1);
    if (sum > limit) return {1'b1, limit[MAX_COUNT_WIDTH-1:0]};
    return sum;
  endfunction

endpackage

// File: rtl/count_connected_lowest_bit_select.sv
// Priority encoder: one-hot of the lowest set bit plus an any-bit-set flag.
module count_connected_lowest_bit_select #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] bits,
  output logic [WIDTH-1:0] lowestOneHot,
  output logic             anySet
);

  // Two's complement isolates the least significant set bit.
  assign lowestOneHot = bits & (~bits + WIDTH'(1));
  assign anySet       = |bits;

endmodule

// File: rtl/count_connected_iterative_core.sv
// Iterative connected-component counter over a 2^VARIABLES boolean lattice, one step per cycle.
// Optional singleton pre-pass enabled by COUNT_CONNECTED_SINGLETON_SHORTCUT_EN.
module count_connected_iterative_core
  import count_connected_iterative_core_pkg::*;
#(
  parameter  int VARIABLES        = 7,
  parameter  int COUNT_WIDTH      = 6,
  parameter  int EXTRA_DATA_WIDTH = 10,
  localparam int GW               = calcGw(VARIABLES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [GW-1:0]               graph_in,
  input  logic [COUNT_WIDTH-1:0]      start_count_in,
  input  logic [EXTRA_DATA_WIDTH-1:0] extra_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [COUNT_WIDTH-1:0]      count_out,
  output logic                        overflow_out,
  output logic [EXTRA_DATA_WIDTH-1:0] extra_out
);

  coreState_t                  stateReg, stateNext;
  logic [GW-1:0]               leftoverReg, leftoverNext;
  logic [GW-1:0]               curReg, curNext;
  logic [COUNT_WIDTH-1:0]      countReg, countNext;
  logic                        overflowReg, overflowNext;
  logic [EXTRA_DATA_WIDTH-1:0] extraReg, extraNext;

  logic [GW-1:0] lowestBit;
  logic          anyLeft;
  maxGraph_t     upCur, downMid;
  logic [GW-1:0] midBits, nxtBits;
  satSum_t       incSum;

  count_connected_lowest_bit_select #(.WIDTH(GW)) lowestSel (
    .bits         (leftoverReg),
    .lowestOneHot (lowestBit),
    .anySet       (anyLeft)
  );

  // One exploration step: grow cur up into leftover, then back down into leftover.
  assign upCur   = monoUp(maxGraph_t'(curReg), VARIABLES);
  assign midBits = upCur[GW-1:0] & leftoverReg;
  assign downMid = monoDown(maxGraph_t'(midBits), VARIABLES);
  assign nxtBits = downMid[GW-1:0] & leftoverReg;
  assign incSum  = satAdd(maxCount_t'(countReg), maxCount_t'(1), COUNT_WIDTH);

  logic unusedBits;
  assign unusedBits = ^{upCur, downMid, incSum};

`ifdef COUNT_CONNECTED_SINGLETON_SHORTCUT_EN
  maxGraph_t     upAll, downAll;
  logic [GW-1:0] isoBits;
  maxCount_t     isoCount;
  satSum_t       pruneSum;

  assign upAll   = monoUp(maxGraph_t'(leftoverReg), VARIABLES);
  assign downAll = monoDown(maxGraph_t'(leftoverReg), VARIABLES);

  // A bit is isolated when no strict subset and no strict superset is present.
  for (genvar gi = 0; gi < GW; gi++) begin : gIso
    logic [VARIABLES-1:0] neighbour;
    for (genvar gv = 0; gv < VARIABLES; gv++) begin : gVar
      if ((gi >> gv) % 2 == 1) begin : gBelow
        assign neighbour[gv] = upAll[gi ^ (1 << gv)];
      end else begin : gAbove
        assign neighbour[gv] = downAll[gi | (1 << gv)];
      end
    end
    assign isoBits[gi] = leftoverReg[gi] & ~(|neighbour);
  end

  always_comb begin
    isoCount = '0;
    for (int i = 0; i < GW; i++) isoCount = isoCount + maxCount_t'(isoBits[i]);
  end

  assign pruneSum = satAdd(maxCount_t'(countReg), isoCount, COUNT_WIDTH);

  logic unusedPrune;
  assign unusedPrune = ^{upAll, downAll, pruneSum};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg    <= IDLE;
      leftoverReg <= '0;
      curReg      <= '0;
      countReg    <= '0;
      overflowReg <= 1'b0;
      extraReg    <= '0;
    end else begin
      stateReg    <= stateNext;
      leftoverReg <= leftoverNext;
      curReg      <= curNext;
      countReg    <= countNext;
      overflowReg <= overflowNext;
      extraReg    <= extraNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    leftoverNext = leftoverReg;
    curNext      = curReg;
    countNext    = countReg;
    overflowNext = overflowReg;
    extraNext    = extraReg;
    case (stateReg)
      IDLE: begin
        if (in_valid) begin
          leftoverNext = graph_in;
          countNext    = start_count_in;
          extraNext    = extra_in;
          overflowNext = 1'b0;
`ifdef COUNT_CONNECTED_SINGLETON_SHORTCUT_EN
          stateNext    = PRUNE;
`else
          stateNext    = SEED;
`endif
        end
      end
`ifdef COUNT_CONNECTED_SINGLETON_SHORTCUT_EN
      PRUNE: begin
        countNext    = pruneSum[COUNT_WIDTH-1:0];
        overflowNext = overflowReg | pruneSum[MAX_COUNT_WIDTH];
        leftoverNext = leftoverReg & ~isoBits;
        stateNext    = SEED;
      end
`endif
      SEED: begin
        if (!anyLeft) begin
          stateNext = DONE;
        end else begin
          curNext      = lowestBit;
          countNext    = incSum[COUNT_WIDTH-1:0];
          overflowNext = overflowReg | incSum[MAX_COUNT_WIDTH];
          stateNext    = EXPLORE;
        end
      end
      EXPLORE: begin
        if (nxtBits == curReg) begin
          leftoverNext = leftoverReg & ~curReg;
          stateNext    = SEED;
        end else begin
          curNext = nxtBits;
        end
      end
      DONE: begin
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign in_ready     = (stateReg == IDLE);
  assign out_valid    = (stateReg == DONE);
  assign count_out    = countReg;
  assign overflow_out = overflowReg;
  assign extra_out    = extraReg;

endmodule

// File: tb/tb_count_connected_iterative_core.sv
// Directed bench for count_connected_iterative_core: default instance plus a 2-bit-count instance.
module tb_count_connected_iterative_core;

  localparam int GW = 128;
  localparam int CW = 6;
  localparam int EW = 10;
  localparam int TIMEOUT = 3000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [GW-1:0] graph_in = '0;
  logic [CW-1:0] start_count_in = '0;
  logic [EW-1:0] extra_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count_out;
  logic          overflow_out;
  logic [EW-1:0] extra_out;

  logic          sInValid = 1'b0;
  logic          sInReady;
  logic [GW-1:0] sGraph = '0;
  logic [1:0]    sStart = '0;
  logic [EW-1:0] sExtra = '0;
  logic          sOutValid;
  logic          sOutReady = 1'b0;
  logic [1:0]    sCount;
  logic          sOverflow;
  logic [EW-1:0] sExtraOut;

  int checks = 0;
  int errors = 0;
  int lat;

  count_connected_iterative_core dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .graph_in       (graph_in),
    .start_count_in (start_count_in),
    .extra_in       (extra_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .count_out      (count_out),
    .overflow_out   (overflow_out),
    .extra_out      (extra_out)
  );

  count_connected_iterative_core #(.COUNT_WIDTH(2)) dutSmall (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (sInValid),
    .in_ready       (sInReady),
    .graph_in       (sGraph),
    .start_count_in (sStart),
    .extra_in       (sExtra),
    .out_valid      (sOutValid),
    .out_ready      (sOutReady),
    .count_out      (sCount),
    .overflow_out   (sOverflow),
    .extra_out      (sExtraOut)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [GW-1:0] g, input logic [CW-1:0] sc, input logic [EW-1:0] ex,
                       output int latency);
    check("in_ready_before_offer", in_ready, 1'b1);
    in_valid = 1'b1;
    graph_in = g;
    start_count_in = sc;
    extra_in = ex;
    @(posedge clk); #1;
    // Scramble inputs after the transfer; the core must ignore them.
    in_valid = 1'b0;
    graph_in = '1;
    start_count_in = '1;
    extra_in = '1;
    latency = 1;
    while (!out_valid && latency < TIMEOUT) begin
      @(posedge clk); #1;
      latency++;
    end
    check("out_valid_within_budget", out_valid, 1'b1);
  endtask

  task automatic collect();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_collect", in_ready, 1'b1);
    check("out_valid_after_collect", out_valid, 1'b0);
  endtask

  task automatic txn(input string tag, input logic [GW-1:0] g, input logic [CW-1:0] sc,
                     input logic [EW-1:0] ex, input logic [CW-1:0] expCount, input logic expOvf);
    int l;
    offer(g, sc, ex, l);
    check({tag, "_count"}, count_out, expCount);
    check({tag, "_overflow"}, overflow_out, expOvf);
    check({tag, "_extra"}, extra_out, ex);
    $display("txn %s graph=%0h start=%0d count=%0d overflow=%0b extra=%0h latency=%0d",
             tag, g, sc, count_out, overflow_out, extra_out, l);
    collect();
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_count", count_out, '0);
    check("reset_overflow", overflow_out, 1'b0);
    check("reset_extra", extra_out, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Empty graph: result visible two cycles after accept (three with the prune pass)
    offer(128'h0, 6'd0, 10'h011, lat);
`ifdef COUNT_CONNECTED_SINGLETON_SHORTCUT_EN
    check("empty_latency", lat, 3);
`else
    check("empty_latency", lat, 2);
`endif
    check("empty_count", count_out, 6'd0);
    check("empty_overflow", overflow_out, 1'b0);
    check("empty_extra", extra_out, 10'h011);
    $display("txn empty count=%0d overflow=%0b latency=%0d", count_out, overflow_out, lat);
    collect();

    txn("incomparable_1_2", 128'h6, 6'd0, 10'h0a1, 6'd2, 1'b0);
    txn("chain_1_3", 128'ha, 6'd0, 10'h0a2, 6'd1, 1'b0);
    txn("pair_1_6", 128'h42, 6'd10, 10'h0a3, 6'd12, 1'b0);
    txn("antichain_1_2_4_8", 128'h116, 6'd0, 10'h0a4, 6'd4, 1'b0);
    txn("join_1_2_3", 128'he, 6'd20, 10'h0a5, 6'd21, 1'b0);
    txn("two_chains", 128'h101a, 6'd0, 10'h0a6, 6'd2, 1'b0);
    txn("bottom_top", {1'b1, 126'h0, 1'b1}, 6'd0, 10'h0a7, 6'd1, 1'b0);
    txn("top_only", {1'b1, 127'h0}, 6'd1, 10'h0a8, 6'd2, 1'b0);
    txn("bit0_only", 128'h1, 6'd7, 10'h0a9, 6'd8, 1'b0);
    txn("saturate_63", 128'h2, 6'd63, 10'h3ff, 6'd63, 1'b1);
    txn("saturate_62", 128'h6, 6'd62, 10'h200, 6'd63, 1'b1);
    txn("all_ones", '1, 6'd5, 10'h155, 6'd6, 1'b0);

    // Small-count instance saturates and flags overflow
    sInValid = 1'b1;
    sGraph = 128'h6;
    sStart = 2'd3;
    sExtra = 10'h077;
    @(posedge clk); #1;
    sInValid = 1'b0;
    sGraph = '0;
    lat = 1;
    while (!sOutValid && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
    check("small_valid", sOutValid, 1'b1);
    check("small_count", sCount, 2'd3);
    check("small_overflow", sOverflow, 1'b1);
    check("small_extra", sExtraOut, 10'h077);
    $display("txn small count=%0d overflow=%0b latency=%0d", sCount, sOverflow, lat);
    sOutReady = 1'b1;
    @(posedge clk); #1;
    sOutReady = 1'b0;
    check("small_in_ready_after", sInReady, 1'b1);

    // Backpressure: result held stable while the collector stalls
    offer(128'h6, 6'd0, 10'h2aa, lat);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_count", count_out, 6'd2);
      check("bp_extra", extra_out, 10'h2aa);
      check("bp_in_ready", in_ready, 1'b0);
    end
    $display("txn backpressure count=%0d extra=%0h", count_out, extra_out);
    collect();
    txn("after_backpressure", 128'h10, 6'd3, 10'h123, 6'd4, 1'b0);

    // Asynchronous reset during exploration discards the partial result
    in_valid = 1'b1;
    graph_in = 128'ha;
    start_count_in = 6'd7;
    extra_in = 10'h155;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", in_ready, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_count", count_out, 6'd0);
    check("abort_overflow", overflow_out, 1'b0);
    check("abort_extra", extra_out, 10'h0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", out_valid, 1'b0);
    end
    $display("txn reset_abort count=%0d out_valid=%0b", count_out, out_valid);
    rst = 1'b1;
    @(posedge clk); #1;
    txn("after_reset_4", 128'h10, 6'd0, 10'h0cc, 6'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
